phy_dlyset_gen: RTL and testbench
=================================

// Module: phy_dlyset_gen
// PURPOSE
//  Parametrised successor of the fixed 9-PHY RX-clock-delay setter. Programs the RGMII RXC 2ns-enable
//  (ext reg 0xA001 bit8) and delay select (ext reg 0xA003 bits[13:10]) on N_PHY PHYs over an APB-style
//  MDIO master (mdio_if_apb, instantiated by the parent). Adds a per-channel enable mask, read-back
//  verification with bounded retry, a per-channel error report, and busy/done status.
// PARAMETERS
//  N_PHY     9                  number of PHY channels (1..16)
//  PHYADDR   {N_PHY{5'b00001}}  packed 5-bit PHY address per channel, ch0 in [4:0]
//  BUSSEL    {N_PHY{4'd0}}      packed 4-bit MDIO bus select per channel, ch0 in [3:0]
//  MAX_RETRY 2                  re-programming attempts after a failed verify (0..7)
// PORTS
//  clk            in   1        system clock
//  rst            in   1        asynchronous active-high reset
//  set_ena        in   1        start pulse; sampled only in IDLE
//  set_chmask     in   N_PHY    1 = program this channel
//  set_rxcdlyena  in   N_PHY    2ns enable per channel
//  set_rxcdlysel  in   4*N_PHY  delay select per channel, ch0 in [3:0]
//  psel           out  1        APB select to mdio_if_apb
//  pwrite         out  1        1 = write, 0 = read
//  paddr          out  16       {bus[3:0], phy[4:0], 1'b0, reg[4:0], 1'b0}
//  pwdata         out  16       write data
//  prdata         in   16       read data, valid with pready on reads
//  pready         in   1        transaction complete
//  busy           out  1        high from accepted set_ena until done
//  done           out  1        1-cycle pulse when all channels have been processed
//  err_mask       out  N_PHY    1 = channel failed verify after all retries; cleared on accepted set_ena
//  dbg_rdback     out  16       last read data
//  dbg_rdback_trg out  1        1-cycle pulse when a read completes
// BEHAVIOUR
//  - Reset: all outputs 0, FSM in IDLE, latched config 0.
//  - Bus: a transaction drives psel=1 with paddr/pwrite/pwdata stable until the cycle where pready=1.
//    The next cycle psel=0 (one idle cycle), then the next transaction issues. A read captures prdata on pready.
//  - IDLE: set_ena=1 latches the mask/ena/sel inputs, clears err_mask, sets busy, ch=0, and goes to SCAN.
//    set_ena while busy is ignored.
//  - SCAN: if ch==N_PHY go to DONE. If mask[ch]=0, then ch+=1 with no bus traffic (1 cycle per channel).
//    Otherwise retry=0, step=0, go to XFER.
//  - XFER steps (rd = read 0x1F):
//      0 W1E=A001   1 rd->A   2 W1E=A001   3 W1F={A[15:9],ena,A[7:0]}
//      4 W1E=A003   5 rd->B   6 W1E=A003   7 W1F={B[15:14],sel,B[9:0]}
//      8 W1E=A001   9 rd->V1  10 W1E=A003  11 rd->V2
//    Each step issues, waits for pready, then idles 1 cycle. After step 11 go to CHECK.
//  - CHECK (1 cycle): pass iff V1[8]==ena && V2[13:10]==sel.
//    On pass: ch+=1, go to SCAN.
//    On fail with retry<MAX_RETRY: retry+=1, restart at step 0.
//    On fail with retry==MAX_RETRY: set err_mask[ch], ch+=1, go to SCAN.
//  - DONE: done=1 for 1 cycle, busy=0, return to IDLE.
//  - Only masked-in channels generate traffic. set_chmask==0 gives busy for N_PHY+2 cycles, then done.
//  - pready outside a pending transaction is ignored. rst mid-transaction drops psel immediately, and the
//    partial PHY write is not recovered.
//  - Counters: ch is clog2(N_PHY+1) bits, retry is 3 bits, step is 4 bits; there is no wrap.
// TESTING
//  - Reset mid-XFER (psel=1): psel, busy, done and err_mask = 0 next edge; a new set_ena runs cleanly.
//  - N_PHY=9, mask=9'h1FF, ena=9'h155, sel=ch index, PHY model stores writes -> 108 transactions
//    (12 per channel) in order; all PHY regs updated; err_mask=0; done pulses once.
//  - mask=9'h004 -> 12 transactions, all with paddr bus/phy = ch2's BUSSEL/PHYADDR;
//    the other regs are untouched.
//  - Model returns A=16'hFFFF, B=16'h0000 -> written data for ena=0, sel=4'hA is
//    0xFEFF and 0x2800.
//  - Model ignores writes to ch3, MAX_RETRY=2 -> ch3 gets 36 transactions, then
//    err_mask=9'h008; the other channels still pass.
//  - set_ena pulsed while busy -> no effect; the latched config is unchanged.

Source files
------------

// File: rtl/phy_dlyset_gen.sv
// -----------------------------------------------------------------------------
// phy_dlyset_gen
//   Programs the RGMII RXC 2ns-enable (ext reg 0xA001 bit 8) and the RXC delay
//   select (ext reg 0xA003 bits [13:10]) on up to N_PHY PHYs through an
//   APB-style MDIO master. Each enabled channel is written with a
//   read-modify-write sequence and then read back. A channel that fails the
//   read-back is reprogrammed up to MAX_RETRY times before it is flagged in
//   err_mask.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   set_ena         start pulse, accepted only while idle
//   set_chmask      per-channel program enable
//   set_rxcdlyena   per-channel 2ns enable value
//   set_rxcdlysel   per-channel 4-bit delay select, ch0 in [3:0]
//   psel/pwrite/paddr/pwdata  request to the MDIO master
//   prdata/pready   response from the MDIO master
//   busy, done      run in progress / 1-cycle end-of-run pulse
//   err_mask        channels that failed verification after all retries
//   dbg_rdback(_trg) last read data / 1-cycle pulse per completed read
// -----------------------------------------------------------------------------
module phy_dlyset_gen #(
  parameter int                   N_PHY     = 9,
  parameter logic [5*N_PHY-1:0]   PHYADDR   = {N_PHY{5'b00001}},
  parameter logic [4*N_PHY-1:0]   BUSSEL    = {N_PHY{4'd0}},
  parameter int                   MAX_RETRY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_ena,
  input  logic [N_PHY-1:0]     set_chmask,
  input  logic [N_PHY-1:0]     set_rxcdlyena,
  input  logic [4*N_PHY-1:0]   set_rxcdlysel,
  output logic                 psel,
  output logic                 pwrite,
  output logic [15:0]          paddr,
  output logic [15:0]          pwdata,
  input  logic [15:0]          prdata,
  input  logic                 pready,
  output logic                 busy,
  output logic                 done,
  output logic [N_PHY-1:0]     err_mask,
  output logic [15:0]          dbg_rdback,
  output logic                 dbg_rdback_trg
);

  localparam int          CH_W         = $clog2(N_PHY + 1);
  localparam logic [4:0]  REG_EXT_ADDR = 5'h1E;
  localparam logic [4:0]  REG_EXT_DATA = 5'h1F;
  localparam logic [15:0] EXT_RXC_ENA  = 16'hA001;
  localparam logic [15:0] EXT_RXC_SEL  = 16'hA003;
  localparam logic [3:0]  LAST_STEP    = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_XFER, S_GAP, S_CHECK, S_DONE
  } state_t;

  state_t              state;
  logic [CH_W-1:0]     ch;
  logic [2:0]          retry;
  logic [3:0]          step;
  logic [N_PHY-1:0]    cfg_mask;
  logic [N_PHY-1:0]    cfg_ena;
  logic [4*N_PHY-1:0]  cfg_sel;
  // Only the bits that are written back or verified are kept.
  logic [14:0]         rd_a;      // {A[15:9], A[7:0]}
  logic [11:0]         rd_b;      // {B[15:14], B[9:0]}
  logic                v1_ena;
  logic [3:0]          v2_sel;

  logic                cur_mask;
  logic                cur_ena;
  logic [3:0]          cur_sel;
  logic [4:0]          cur_phy;
  logic [3:0]          cur_bus;
  logic [N_PHY-1:0]    cur_bit;
  logic [3:0]          nxt_step;
  logic                req_write;
  logic [4:0]          req_reg;
  logic [15:0]         req_data;
  logic [15:0]         req_addr;
  logic                verify_ok;

  // Per-channel selection and the request for the next bus step.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    cur_mask  = 1'b0;
    cur_ena   = 1'b0;
    cur_sel   = '0;
    cur_phy   = '0;
    cur_bus   = '0;
    cur_bit   = '0;
    for (int i = 0; i < N_PHY; i++) begin
      if (ch == CH_W'(i)) begin
        cur_mask   = cfg_mask[i];
        cur_ena    = cfg_ena[i];
        cur_sel    = cfg_sel[4*i +: 4];
        cur_phy    = PHYADDR[5*i +: 5];
        cur_bus    = BUSSEL[4*i +: 4];
        cur_bit[i] = 1'b1;
      end
    end

    // Issues happen from SCAN/CHECK (step 0) or from GAP (following step).
    nxt_step  = (state == S_GAP) ? step + 4'd1 : 4'd0;
    req_write = 1'b1;
    req_reg   = REG_EXT_ADDR;
    req_data  = '0;
    case (nxt_step)
      4'd0, 4'd2, 4'd8:   req_data = EXT_RXC_ENA;
      4'd4, 4'd6, 4'd10:  req_data = EXT_RXC_SEL;
      4'd1, 4'd5, 4'd9, 4'd11: begin
        req_write = 1'b0;
        req_reg   = REG_EXT_DATA;
      end
      4'd3: begin
        req_reg  = REG_EXT_DATA;
        req_data = {rd_a[14:8], cur_ena, rd_a[7:0]};
      end
      4'd7: begin
        req_reg  = REG_EXT_DATA;
        req_data = {rd_b[11:10], cur_sel, rd_b[9:0]};
      end
      default: ;
    endcase
    req_addr  = {cur_bus, cur_phy, 1'b0, req_reg, 1'b0};
    verify_ok = (v1_ena == cur_ena) && (v2_sel == cur_sel);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      ch             <= '0;
      retry          <= '0;
      step           <= '0;
      cfg_mask       <= '0;
      cfg_ena        <= '0;
      cfg_sel        <= '0;
      rd_a           <= '0;
      rd_b           <= '0;
      v1_ena         <= 1'b0;
      v2_sel         <= '0;
      psel           <= 1'b0;
      pwrite         <= 1'b0;
      paddr          <= '0;
      pwdata         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_mask       <= '0;
      dbg_rdback     <= '0;
      dbg_rdback_trg <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register sees pre-edge values regardless of statement order.
      done           <= 1'b0;
      dbg_rdback_trg <= 1'b0;
      case (state)
        S_IDLE: begin
          if (set_ena) begin
            cfg_mask <= set_chmask;
            cfg_ena  <= set_rxcdlyena;
            cfg_sel  <= set_rxcdlysel;
            err_mask <= '0;
            busy     <= 1'b1;
            ch       <= '0;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (ch == CH_W'(N_PHY)) begin
            state <= S_DONE;
          end else if (!cur_mask) begin
            ch <= ch + CH_W'(1);
          end else begin
            retry  <= '0;
            step   <= '0;
            psel   <= 1'b1;
            pwrite <= req_write;
            paddr  <= req_addr;
            pwdata <= req_data;
            state  <= S_XFER;
          end
        end
        S_XFER: begin
          if (pready) begin
            psel <= 1'b0;
            if (!pwrite) begin
              dbg_rdback     <= prdata;
              dbg_rdback_trg <= 1'b1;
              case (step)
                4'd1:    rd_a   <= {prdata[15:9], prdata[7:0]};
                4'd5:    rd_b   <= {prdata[15:14], prdata[9:0]};
                4'd9:    v1_ena <= prdata[8];
                4'd11:   v2_sel <= prdata[13:10];
                default: ;
              endcase
            end
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (step == LAST_STEP) begin
            state <= S_CHECK;
          end else begin
            step   <= nxt_step;
            psel   <= 1'b1;
            pwrite <= req_write;
            paddr  <= req_addr;
            pwdata <= req_data;
            state  <= S_XFER;
          end
        end
        S_CHECK: begin
          if (verify_ok) begin
            ch    <= ch + CH_W'(1);
            state <= S_SCAN;
          end else if (retry < 3'(MAX_RETRY)) begin
            retry  <= retry + 3'd1;
            step   <= '0;
            psel   <= 1'b1;
            pwrite <= req_write;
            paddr  <= req_addr;
            pwdata <= req_data;
            state  <= S_XFER;
          end else begin
            err_mask <= err_mask | cur_bit;
            ch       <= ch + CH_W'(1);
            state    <= S_SCAN;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_dlyset_gen.sv
// -----------------------------------------------------------------------------
// tb_phy_dlyset_gen
//   Directed bench for phy_dlyset_gen with N_PHY=9. A behavioural MDIO/PHY
//   model answers bus requests (optional wait states), stores ext-register
//   writes, logs every transaction and watches the bus handshake rules.
//   Channel c uses PHY address c+1 and bus select 15-c.
// -----------------------------------------------------------------------------
module tb_phy_dlyset_gen;

  localparam int N = 9;
  localparam logic [5*N-1:0] TB_PHYADDR =
    {5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [4*N-1:0] TB_BUSSEL =
    {4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
  localparam logic [4*N-1:0] SEL_IDX =
    {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};

  logic            clk = 1'b0;
  logic            rst;
  logic            set_ena;
  logic [N-1:0]    set_chmask;
  logic [N-1:0]    set_rxcdlyena;
  logic [4*N-1:0]  set_rxcdlysel;
  logic            psel, pwrite;
  logic [15:0]     paddr, pwdata, prdata;
  logic            pready;
  logic            busy, done;
  logic [N-1:0]    err_mask;
  logic [15:0]     dbg_rdback;
  logic            dbg_rdback_trg;

  phy_dlyset_gen #(
    .N_PHY(N), .PHYADDR(TB_PHYADDR), .BUSSEL(TB_BUSSEL), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst), .set_ena(set_ena), .set_chmask(set_chmask),
    .set_rxcdlyena(set_rxcdlyena), .set_rxcdlysel(set_rxcdlysel),
    .psel(psel), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .busy(busy), .done(done),
    .err_mask(err_mask), .dbg_rdback(dbg_rdback), .dbg_rdback_trg(dbg_rdback_trg)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model ---
  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  txn_t        log_q[$];
  logic [15:0] r_a001[N];
  logic [15:0] r_a003[N];
  logic [15:0] ini_a001[N];
  logic [15:0] ini_a003[N];
  bit          ext_hi[N];
  int          ign_ch = -1;
  int          lat = 0;
  int          wcnt = 0;
  int          proto_err = 0;
  int          bad_addr = 0;
  int          trg_cnt = 0;
  bit          hold = 1'b0;
  logic [15:0] hold_addr, hold_data;
  logic        hold_wr;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic serve();
    int         c;
    logic [4:0] r;
    c = int'(paddr[11:7]) - 1;
    r = paddr[5:1];
    if (c < 0 || c >= N || paddr[15:12] != 4'(15 - c) || paddr[6] || paddr[0]) begin
      bad_addr++;
      prdata = 16'hDEAD;
    end else if (pwrite) begin
      if (r == 5'h1E) ext_hi[c] = (pwdata == 16'hA003);
      else if (c != ign_ch) begin
        if (ext_hi[c]) r_a003[c] = pwdata;
        else           r_a001[c] = pwdata;
      end
    end else begin
      prdata = ext_hi[c] ? r_a003[c] : r_a001[c];
    end
    log_q.push_back('{pwrite, paddr, pwrite ? pwdata : prdata});
  endtask

  initial begin
    pready = 1'b0;
    prdata = '0;
    forever begin
      @(negedge clk);
      if (dbg_rdback_trg) trg_cnt++;
      if (!rst) begin
        if (pready && psel) proto_err++;   // no idle cycle after completion
        if (hold && (!psel || paddr !== hold_addr || pwrite !== hold_wr ||
                     pwdata !== hold_data)) proto_err++;
      end
      if (pready)      pready = 1'b0;
      else if (psel && !rst) begin
        if (wcnt < lat) wcnt++;
        else begin
          wcnt = 0;
          serve();
          pready = 1'b1;
        end
      end else wcnt = 0;
      hold      = psel && !pready && !rst;
      hold_addr = paddr;
      hold_wr   = pwrite;
      hold_data = pwdata;
    end
  end

  // --------------------------------------------------------------- helpers ---
  task automatic preload();
    for (int c = 0; c < N; c++) begin
      r_a001[c]   = 16'h5A00 + 16'(c);
      r_a003[c]   = 16'hC300 + 16'(c);
      ini_a001[c] = r_a001[c];
      ini_a003[c] = r_a003[c];
      ext_hi[c]   = 1'b0;
    end
  endtask

  function automatic logic [15:0] exp_addr(input int c, input logic [4:0] r);
    logic [3:0] b;
    logic [4:0] p;
    b = 4'(15 - c);
    p = 5'(c + 1);
    return {b, p, 1'b0, r, 1'b0};
  endfunction

  // Mismatching transactions in one 12-step channel sequence starting at base.
  function automatic int seq_bad(input int base, input int c, input logic e,
                                 input logic [3:0] s);
    int          bad;
    logic [15:0] a, b, ed;
    logic        ew;
    logic [4:0]  er;
    txn_t        t;
    bad = 0;
    a   = '0;
    b   = '0;
    for (int k = 0; k < 12; k++) begin
      if (base + k >= log_q.size()) begin
        bad++;
        continue;
      end
      t  = log_q[base + k];
      ew = !(k == 1 || k == 5 || k == 9 || k == 11);
      er = (k % 2 == 1) ? 5'h1F : 5'h1E;
      case (k)
        0, 2, 8:  ed = 16'hA001;
        4, 6, 10: ed = 16'hA003;
        3:        ed = {a[15:9], e, a[7:0]};
        7:        ed = {b[15:14], s, b[9:0]};
        default:  ed = t.data;
      endcase
      if (t.wr !== ew || t.addr !== exp_addr(c, er) || t.data !== ed) bad++;
      if (k == 1) a = t.data;
      if (k == 5) b = t.data;
    end
    return bad;
  endfunction

  task automatic run(input logic [N-1:0] m, input logic [N-1:0] e,
                     input logic [4*N-1:0] s, input bit poke,
                     output int bc, output int dc, output bit to);
    @(posedge clk); #1;
    set_chmask    = m;
    set_rxcdlyena = e;
    set_rxcdlysel = s;
    set_ena       = 1'b1;
    @(posedge clk); #1;
    set_ena = 1'b0;
    bc = 0;
    dc = 0;
    to = 1'b1;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (poke && k == 50) begin
        set_ena = 1'b1; set_chmask = ~m; set_rxcdlyena = ~e; set_rxcdlysel = ~s;
      end
      if (poke && k == 51) begin
        set_ena = 1'b0; set_chmask = m; set_rxcdlyena = e; set_rxcdlysel = s;
      end
      if (busy) bc++;
      if (done) begin
        dc++;
        to = 1'b0;
        break;
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (done) dc++;
    end
  endtask

  // -------------------------------------------------------------- stimulus ---
  int          bc, dc, bad, base;
  bit          to;
  logic [15:0] snap1[N];
  logic [15:0] snap3[N];
  logic [15:0] e1, e3;
  logic [3:0]  sv;

  initial begin
    rst = 1'b1;
    set_ena = 1'b0;
    set_chmask = '0;
    set_rxcdlyena = '0;
    set_rxcdlysel = '0;
    preload();
    repeat (3) @(posedge clk);
    #1;
    check("rst_psel", psel, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_mask, 0);
    check("rst_dbg", dbg_rdback, 0);
    check("rst_trg", dbg_rdback_trg, 0);
    rst = 1'b0;

    // Empty mask: N+2 busy cycles, no traffic.
    log_q.delete();
    run('0, '0, '0, 1'b0, bc, dc, to);
    check("m0_timeout", to, 0);
    check("m0_busy_cycles", bc, N + 2);
    check("m0_done", dc, 1);
    check("m0_txns", log_q.size(), 0);

    // All channels, with a set_ena pulse mid-run that must be ignored.
    preload();
    log_q.delete();
    trg_cnt = 0;
    run('1, 9'h155, SEL_IDX, 1'b1, bc, dc, to);
    check("full_timeout", to, 0);
    check("full_done", dc, 1);
    check("full_txns", log_q.size(), 108);
    bad = 0;
    for (int c = 0; c < N; c++) bad += seq_bad(12 * c, c, 1'(9'h155 >> c), SEL_IDX[4*c +: 4]);
    check("full_seq", bad, 0);
    bad = 0;
    for (int c = 0; c < N; c++) begin
      e1 = (ini_a001[c] & ~16'h0100) | (16'(1'(9'h155 >> c)) << 8);
      sv = SEL_IDX[4*c +: 4];
      e3 = (ini_a003[c] & ~16'h3C00) | (16'(sv) << 10);
      if (r_a001[c] !== e1 || r_a003[c] !== e3) bad++;
    end
    check("full_regs", bad, 0);
    check("full_err", err_mask, 0);
    check("full_trg", trg_cnt, 36);
    check("full_dbg", dbg_rdback, log_q[107].data);
    check("full_proto", proto_err, 0);
    check("full_addr", bad_addr, 0);

    // Single channel 2; everything else must stay untouched.
    for (int c = 0; c < N; c++) begin
      snap1[c] = r_a001[c];
      snap3[c] = r_a003[c];
    end
    log_q.delete();
    run(9'h004, 9'h000, {N{4'hF}}, 1'b0, bc, dc, to);
    check("ch2_timeout", to, 0);
    check("ch2_txns", log_q.size(), 12);
    check("ch2_seq", seq_bad(0, 2, 1'b0, 4'hF), 0);
    bad = 0;
    for (int c = 0; c < N; c++) begin
      if (c == 2) begin
        if (r_a001[c] !== (snap1[c] & ~16'h0100) ||
            r_a003[c] !== (snap3[c] | 16'h3C00)) bad++;
      end else if (r_a001[c] !== snap1[c] || r_a003[c] !== snap3[c]) bad++;
    end
    check("ch2_regs", bad, 0);
    check("ch2_err", err_mask, 0);

    // Read-modify-write keeps the other bits, with wait states on the bus.
    r_a001[0] = 16'hFFFF;
    r_a003[0] = 16'h0000;
    lat = 2;
    log_q.delete();
    run(9'h001, 9'h000, 36'hA, 1'b0, bc, dc, to);
    lat = 0;
    check("rmw_timeout", to, 0);
    check("rmw_txns", log_q.size(), 12);
    check("rmw_w_ena", log_q[3].data, 16'hFEFF);
    check("rmw_w_sel", log_q[7].data, 16'h2800);
    check("rmw_err", err_mask, 0);
    check("rmw_proto", proto_err, 0);

    // Channel 3 ignores writes: three attempts, then flagged.
    preload();
    r_a001[3] = 16'h0000;
    r_a003[3] = 16'h0000;
    ign_ch = 3;
    log_q.delete();
    run('1, '1, {N{4'h5}}, 1'b0, bc, dc, to);
    ign_ch = -1;
    check("retry_timeout", to, 0);
    check("retry_done", dc, 1);
    check("retry_txns", log_q.size(), 132);
    bad = 0;
    base = 0;
    for (int c = 0; c < N; c++) begin
      for (int r = 0; r < ((c == 3) ? 3 : 1); r++) begin
        bad += seq_bad(base, c, 1'b1, 4'h5);
        base += 12;
      end
    end
    check("retry_seq", bad, 0);
    check("retry_err", err_mask, 9'h008);

    // Reset while a transaction is pending, then a clean run.
    @(posedge clk); #1;
    set_chmask = '1; set_rxcdlyena = '0; set_rxcdlysel = '0; set_ena = 1'b1;
    @(posedge clk); #1;
    set_ena = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (psel) begin
        to = 1'b0;
        break;
      end
    end
    check("mid_psel_seen", to, 0);
    #2 rst = 1'b1;
    #1 check("mid_async_psel", psel, 0);
    @(posedge clk); #1;
    check("mid_psel", psel, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_err", err_mask, 0);
    @(negedge clk); #2 rst = 1'b0;
    log_q.delete();
    proto_err = 0;
    run(9'h002, 9'h002, 36'h70, 1'b0, bc, dc, to);
    check("post_timeout", to, 0);
    check("post_done", dc, 1);
    check("post_txns", log_q.size(), 12);
    check("post_seq", seq_bad(0, 1, 1'b1, 4'h7), 0);
    check("post_err", err_mask, 0);
    check("post_proto", proto_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
